// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start-bit request, then shifts
// a command byte out on device-generated clocks and checks the device's line-level ACK.
module ps2_host_tx #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int INHIBIT_CYCLES  = 6000,
    parameter int REQ_TIMEOUT     = 750000,
    parameter int BIT_TIMEOUT     = 10000
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iSend,
    input  logic [7:0] iData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    input  logic       iPS2Clk,
    input  logic       iPS2Dat,
    output logic       oPS2ClkLow,
    output logic       oPS2DatLow
);

    if (CLOCK_FREQUENCY <= 0 || INHIBIT_CYCLES < 1 || REQ_TIMEOUT < 1 || BIT_TIMEOUT < 1 ||
        INHIBIT_CYCLES > 1048575 || REQ_TIMEOUT > 1048575 || BIT_TIMEOUT > 1048575) begin : g_param_check
        $error("ps2_host_tx: cycle counts must be positive and fit the 20-bit counter");
    end

    localparam logic [19:0] LP_INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] LP_REQ_LAST     = 20'(REQ_TIMEOUT - 1);
    localparam logic [19:0] LP_BIT_LAST     = 20'(BIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_RELEASE,
        S_SHIFT,
        S_ACK,
        S_WAITIDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_clk_meta;
    logic        r_clk_sync;
    logic        r_clk_prev;
    logic        r_dat_meta;
    logic        r_dat_sync;
    logic        w_fe;
    logic        w_fe_clear;
    logic        w_dat_low_next;
    logic [19:0] r_cnt;
    logic [3:0]  r_bitcnt;
    logic [9:0]  r_frame;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_clk_low;
    logic        r_dat_low;

    // NOTE: synchronisers reset to the idle (high) line level so reset never fakes a falling edge.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= iPS2Clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= iPS2Dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fe = r_clk_prev & ~r_clk_sync;
    // Our own CLK pull during INHIBIT also produces an edge; only device edges may restart cnt.
    assign w_fe_clear = w_fe && (r_state == S_RELEASE || r_state == S_SHIFT || r_state == S_ACK);

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every variable of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (iSend) w_next_state = S_INHIBIT;
            S_INHIBIT:  if (r_cnt == LP_INHIBIT_LAST) w_next_state = S_REQ;
            S_REQ:      w_next_state = S_RELEASE;
            S_RELEASE: begin
                if (w_fe) w_next_state = S_SHIFT;
                else if (r_cnt == LP_REQ_LAST) w_next_state = S_ERR;
            end
            S_SHIFT: begin
                if (w_fe) begin
                    if (r_bitcnt == 4'd8) w_next_state = S_ACK;
                end else if (r_cnt == LP_BIT_LAST) begin
                    w_next_state = S_ERR;
                end
            end
            S_ACK: begin
                if (w_fe) w_next_state = r_dat_sync ? S_ERR : S_WAITIDLE;
                else if (r_cnt == LP_BIT_LAST) w_next_state = S_ERR;
            end
            S_WAITIDLE: begin
                if (r_clk_sync && r_dat_sync) w_next_state = S_DONE;
                else if (r_cnt == LP_BIT_LAST) w_next_state = S_ERR;
            end
            S_DONE:     w_next_state = S_IDLE;
            S_ERR:      w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase

        w_dat_low_next = 1'b0;
        case (w_next_state)
            S_REQ, S_RELEASE: w_dat_low_next = 1'b1;
            S_SHIFT:          w_dat_low_next = w_fe ? ~r_frame[0] : r_dat_low;
            default:          w_dat_low_next = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_frame   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b0;
        end else begin
            if (w_next_state != r_state || w_fe_clear) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 20'd1;
            end

            // Frame is {stop, odd parity, data}; bit 0 is always the next bit to put on DAT.
            if (r_state == S_IDLE && iSend) begin
                r_frame <= {1'b1, ~^iData, iData};
            end else if (w_fe && (r_state == S_RELEASE || r_state == S_SHIFT)) begin
                r_frame <= {1'b0, r_frame[9:1]};
            end

            if (w_fe && r_state == S_RELEASE) begin
                r_bitcnt <= '0;
            end else if (w_fe && r_state == S_SHIFT) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
            r_error   <= (w_next_state == S_ERR);
            r_clk_low <= (w_next_state == S_INHIBIT || w_next_state == S_REQ);
            r_dat_low <= w_dat_low_next;
        end
    end

    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oError     = r_error;
    assign oPS2ClkLow = r_clk_low;
    assign oPS2DatLow = r_dat_low;

endmodule
